// File: rtl/expander_pkg.sv
// Shared definitions for the PCA9555-style GPIO expander: register map, responder states
// and reset values. Also imported by the expander masters.
package expander_pkg;

    typedef enum logic [2:0] {
        REG_IN0  = 3'd0,
        REG_IN1  = 3'd1,
        REG_OUT0 = 3'd2,
        REG_OUT1 = 3'd3,
        REG_POL0 = 3'd4,
        REG_POL1 = 3'd5,
        REG_CFG0 = 3'd6,
        REG_CFG1 = 3'd7
    } reg_idx_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_PTR,
        ST_WDATA,
        ST_RDATA,
        ST_IGNORE
    } state_e;

    localparam logic [15:0] OUT_RST = 16'hFFFF;
    localparam logic [15:0] POL_RST = 16'h0000;
    localparam logic [15:0] CFG_RST = 16'hFFFF;

    // Auto-increment stays inside the low/high byte pair of one 16-bit register.
    function automatic logic [2:0] ptr_pair_toggle(input logic [2:0] p);
        return {p[2:1], ~p[0]};
    endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// Synchronises and glitch-filters SCL/SDA and produces one-cycle edge, START and STOP strobes.
module i2c_line_filter #(
    parameter int FILTER_CYCLES = 3
) (
    input  logic clk_50,
    input  logic rst_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    localparam int CW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(FILTER_CYCLES - 1);

    // bit 0 = SCL, bit 1 = SDA; idle bus level is high
    logic [1:0]         sync1;
    logic [1:0]         sync2;
    logic [1:0]         filt;
    logic [1:0]         filt_d;
    logic [1:0][CW-1:0] cnt;

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= 2'b11;
            sync2  <= 2'b11;
            filt   <= 2'b11;
            filt_d <= 2'b11;
            cnt    <= {2{CNT_LOAD}};
        end else begin
            sync1  <= {sda_in, scl_in};
            sync2  <= sync1;
            filt_d <= filt;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    cnt[i] <= CNT_LOAD;
                end else if (cnt[i] == '0) begin
                    filt[i] <= sync2[i];
                    cnt[i]  <= CNT_LOAD;
                end else begin
                    cnt[i] <= cnt[i] - 1'b1;
                end
            end
        end
    end

    assign sda      = filt[1];
    assign scl_rise =  filt[0] & ~filt_d[0];
    assign scl_fall = ~filt[0] &  filt_d[0];
    assign start    =  filt[0] &  filt_d[0] &  filt_d[1] & ~filt[1];
    assign stop     =  filt[0] &  filt_d[0] & ~filt_d[1] &  filt[1];

endmodule

// File: rtl/i2c_expander_responder.sv
// I2C target emulating a 16-bit PCA9555-style GPIO expander; open-drain SDA, no clock stretching.
//   state     | meaning
//   ST_IDLE   | bus free, waiting for START
//   ST_ADDR   | shifting address byte, ACK on match
//   ST_PTR    | receiving register pointer
//   ST_WDATA  | receiving data bytes into registers
//   ST_RDATA  | driving register bytes, sampling master ACK
//   ST_IGNORE | not addressed or master NACKed; wait for START/STOP
import expander_pkg::*;

module i2c_expander_responder #(
    parameter logic [6:0] DEV_ADDR      = 7'h20,
    parameter int         FILTER_CYCLES = 3
) (
    input  logic        clk_50,
    input  logic        rst_n,
    input  logic        i2c_scl_i,
    input  logic        i2c_sda_i,
    output logic        i2c_sda_oe,
    input  logic [15:0] gpio_in,
    output logic [15:0] gpio_out,
    output logic [15:0] gpio_oe,
    output logic        int_n
);

    logic sda_f, scl_rise, scl_fall, start, stop;

    i2c_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_line_filter (
        .clk_50   (clk_50),
        .rst_n    (rst_n),
        .scl_in   (i2c_scl_i),
        .sda_in   (i2c_sda_i),
        .sda      (sda_f),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop)
    );

    state_e      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [7:0]  shreg, shreg_nxt;
    logic [2:0]  ptr, ptr_nxt;
    logic        sda_oe, sda_oe_nxt;
    logic [15:0] out_reg, out_nxt;
    logic [15:0] pol_reg, pol_nxt;
    logic [15:0] cfg_reg, cfg_nxt;
    logic [15:0] snap, snap_nxt;
    logic [15:0] gpio_meta, gpio_s;
    logic [15:0] reg_word;
    logic [7:0]  rd_byte;
    logic [7:0]  rx_byte;
    logic        load_rd;

    always_comb begin
        reg_word = gpio_s ^ pol_reg;
        case (ptr[2:1])
            2'd1:    reg_word = out_reg;
            2'd2:    reg_word = pol_reg;
            2'd3:    reg_word = cfg_reg;
            default: reg_word = gpio_s ^ pol_reg;
        endcase
        rd_byte = ptr[0] ? reg_word[15:8] : reg_word[7:0];
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            shreg     <= '0;
            ptr       <= '0;
            sda_oe    <= 1'b0;
            out_reg   <= OUT_RST;
            pol_reg   <= POL_RST;
            cfg_reg   <= CFG_RST;
            snap      <= '0;
            gpio_meta <= '0;
            gpio_s    <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            shreg     <= shreg_nxt;
            ptr       <= ptr_nxt;
            sda_oe    <= sda_oe_nxt;
            out_reg   <= out_nxt;
            pol_reg   <= pol_nxt;
            cfg_reg   <= cfg_nxt;
            snap      <= snap_nxt;
            gpio_meta <= gpio_in;
            gpio_s    <= gpio_meta;
        end
    end

    // cnt counts SCL rises within a byte; 8 = ACK slot pending, 9 = inside the ACK clock
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        shreg_nxt  = shreg;
        ptr_nxt    = ptr;
        sda_oe_nxt = sda_oe;
        out_nxt    = out_reg;
        pol_nxt    = pol_reg;
        cfg_nxt    = cfg_reg;
        snap_nxt   = snap;
        load_rd    = 1'b0;
        rx_byte    = {shreg[6:0], sda_f};

        if (stop) begin
            state_nxt  = ST_IDLE;
            sda_oe_nxt = 1'b0;
            cnt_nxt    = '0;
        end else if (start) begin
            state_nxt  = ST_ADDR;
            sda_oe_nxt = 1'b0;
            cnt_nxt    = '0;
        end else begin
            case (state)
                ST_ADDR, ST_PTR, ST_WDATA: begin
                    if (scl_rise && cnt < 4'd8) begin
                        shreg_nxt = rx_byte;
                        cnt_nxt   = cnt + 4'd1;
                        if (cnt == 4'd7 && state == ST_PTR) begin
                            ptr_nxt = rx_byte[2:0];
                        end
                        if (cnt == 4'd7 && state == ST_WDATA) begin
                            case (reg_idx_e'(ptr))
                                REG_OUT0: out_nxt[7:0]  = rx_byte;
                                REG_OUT1: out_nxt[15:8] = rx_byte;
                                REG_POL0: pol_nxt[7:0]  = rx_byte;
                                REG_POL1: pol_nxt[15:8] = rx_byte;
                                REG_CFG0: cfg_nxt[7:0]  = rx_byte;
                                REG_CFG1: cfg_nxt[15:8] = rx_byte;
                                default:  ;
                            endcase
                            ptr_nxt = ptr_pair_toggle(ptr);
                        end
                    end else if (scl_fall && cnt == 4'd8) begin
                        if (state == ST_ADDR && shreg[7:1] != DEV_ADDR) begin
                            state_nxt = ST_IGNORE;
                        end else begin
                            sda_oe_nxt = 1'b1;
                            cnt_nxt    = 4'd9;
                        end
                    end else if (scl_fall && cnt == 4'd9) begin
                        sda_oe_nxt = 1'b0;
                        cnt_nxt    = '0;
                        if (state == ST_PTR) begin
                            state_nxt = ST_WDATA;
                        end else if (state == ST_ADDR) begin
                            if (shreg[0]) begin
                                state_nxt = ST_RDATA;
                                load_rd   = 1'b1;
                            end else begin
                                state_nxt = ST_PTR;
                            end
                        end
                    end
                end
                ST_RDATA: begin
                    if (scl_rise) begin
                        if (cnt < 4'd8) begin
                            cnt_nxt = cnt + 4'd1;
                        end else if (cnt == 4'd9) begin
                            if (sda_f) begin
                                state_nxt  = ST_IGNORE;
                                sda_oe_nxt = 1'b0;
                            end else begin
                                ptr_nxt = ptr_pair_toggle(ptr);
                            end
                        end
                    end else if (scl_fall) begin
                        if (cnt == 4'd8) begin
                            sda_oe_nxt = 1'b0;
                            cnt_nxt    = 4'd9;
                        end else if (cnt == 4'd9) begin
                            load_rd = 1'b1;
                            cnt_nxt = '0;
                        end else if (cnt != 4'd0) begin
                            shreg_nxt  = {shreg[6:0], 1'b0};
                            sda_oe_nxt = ~shreg[6];
                        end
                    end
                end
                default: sda_oe_nxt = 1'b0;
            endcase

            if (load_rd) begin
                shreg_nxt  = rd_byte;
                sda_oe_nxt = ~rd_byte[7];
                if (ptr[2:1] == 2'd0) begin
                    snap_nxt = gpio_s;
                end
            end
        end
    end

    assign i2c_sda_oe = sda_oe;
    assign gpio_out   = out_reg;
    assign gpio_oe    = ~cfg_reg;
    assign int_n      = (gpio_s == snap);

endmodule
